obuf_rd_arbiter: RTL and testbench

Shares the single OBUF read port between the PU load walker, requester 0, and the store/drain path, requester 1. Each requester issues multi-beat transactions, for example NUM_FIFO sub-word beats per logical address. The arbiter grants one requester at a time with round-robin fairness and holds the grant until the requester's last beat. It records the owner of every accepted beat so the returning read-valid strobes go back to the correct requester.

---
 rtl/obuf_rd_arbiter_pkg.sv | 12 +
 rtl/obuf_rd_id_fifo.sv | 52 +++++
 rtl/obuf_rd_arbiter.sv | 131 +++++++++++++
 tb/tb_obuf_rd_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obuf_rd_arbiter_pkg.sv
// Shared types and constants for the OBUF read-port arbiter.
package obuf_rd_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned REQ_PU_LD = 0;
  localparam int unsigned REQ_ST    = 1;

endpackage

// File: rtl/obuf_rd_id_fifo.sv
// Small synchronous FIFO that remembers the owning requester of each
// accepted-but-unreturned OBUF read beat.
module obuf_rd_id_fifo #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/obuf_rd_arbiter.sv
// Round-robin arbiter sharing the OBUF read port between multi-beat
// requesters; steers returning read-valid strobes back to the beat owner.
module obuf_rd_arbiter
  import obuf_rd_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned ID_W          = $clog2(NUM_REQ),
  parameter int unsigned RD_FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_v,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          mem_req,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic                          mem_ready,
  input  logic                          mem_rd_v,
  output logic [NUM_REQ-1:0]            rd_v,
  output logic                          busy,
  output logic                          err
);

  localparam int unsigned CNT_W = $clog2(RD_FIFO_DEPTH) + 1;

  if (NUM_REQ < 2 || NUM_REQ > 4 || REQ_ST >= NUM_REQ) begin : g_bad_cfg
    $error("obuf_rd_arbiter: NUM_REQ must be 2..4");
  end

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  head_id;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0] fifo_cnt, fifo_cnt_d;
  logic             busy_q, err_q;

  // First valid requester at or after ptr, searching circularly.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]    ptr);
    logic            found;
    logic [ID_W-1:0] cand;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && v[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    mem_req   = 1'b0;
    req_ready = '0;
    mem_addr  = '0;
    winner    = rr_pick(req_v, rr_ptr_q);
    unique case (state_q)
      ST_IDLE: begin
        if (|req_v) begin
          state_d = ST_LOCKED;
          owner_d = winner;
        end
      end
      ST_LOCKED: begin
        mem_req = req_v[owner_q] && mem_ready && !fifo_full;
        if (mem_req) begin
          req_ready[owner_q] = 1'b1;
          mem_addr = req_addr[32'(owner_q) * ADDR_WIDTH +: ADDR_WIDTH];
          if (req_last[owner_q]) begin
            state_d  = ST_IDLE;
            rr_ptr_d = (32'(owner_q) + 1 == NUM_REQ) ? '0 : owner_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_v     = '0;
    fifo_pop = mem_rd_v && !fifo_empty;
    if (fifo_pop) rd_v[head_id] = 1'b1;
  end

  // busy is registered, so it is derived from next-cycle state and occupancy.
  assign fifo_cnt_d = fifo_cnt + CNT_W'(mem_req) - CNT_W'(fifo_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= ID_W'(REQ_PU_LD);
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= (state_d == ST_LOCKED) || (fifo_cnt_d != '0);
      err_q    <= err_q | (mem_rd_v & fifo_empty);
    end
  end

  assign busy = busy_q;
  assign err  = err_q;

  obuf_rd_id_fifo #(
    .W     (ID_W),
    .DEPTH (RD_FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (mem_req),
    .push_data (owner_q),
    .pop       (fifo_pop),
    .pop_data  (head_id),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_obuf_rd_arbiter.sv
// Scenario bench for obuf_rd_arbiter: expected beat owners are queued when
// an accept is expected and compared against rd_v when the return is driven.
module tb_obuf_rd_arbiter;
  import obuf_rd_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_v, req_last, req_ready, rd_v;
  logic [15:0] req_addr;
  logic        mem_req, mem_ready, mem_rd_v, busy, err;
  logic [7:0]  mem_addr;

  int errors = 0;
  int checks = 0;
  int exp_id_q[$];
  int ret_q[$];

  obuf_rd_arbiter #(
    .ADDR_WIDTH    (8),
    .NUM_REQ       (2),
    .RD_FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_v     (req_v),
    .req_addr  (req_addr),
    .req_last  (req_last),
    .req_ready (req_ready),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rd_v  (mem_rd_v),
    .rd_v      (rd_v),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    req_v = '0; req_last = '0; req_addr = '0; mem_ready = 1'b0; mem_rd_v = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_id_q.delete();
    ret_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    mem_rd_v = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_addr, req_ready, rd_v, busy, err} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {mem_req, mem_addr, req_ready, rd_v, busy, err});
    end
    mem_rd_v = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [1:0] exp_rdy;
    logic [7:0] exp_addr;
    int id;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req_v     = (c <= 2) ? 2'b01 : 2'b00;
      req_addr  = {8'h00, (c <= 1) ? 8'h10 : 8'h11};
      req_last  = (c == 2) ? 2'b01 : 2'b00;
      mem_ready = 1'b1;
      mem_rd_v  = (ret_q.size() > 0) && (ret_q[0] == c);
      #1;
      exp_rdy = (c == 1 || c == 2) ? 2'b01 : 2'b00;
      checks++;
      if ({mem_req, req_ready} !== {exp_rdy[0], exp_rdy}) begin
        errors++;
        $display("FAIL single_accept c=%0d: got req=%b rdy=%b expected %b", c, mem_req, req_ready, exp_rdy);
      end
      if (exp_rdy != 2'b00) begin
        exp_addr = (c == 1) ? 8'h10 : 8'h11;
        checks++;
        if (mem_addr !== exp_addr) begin
          errors++;
          $display("FAIL single_addr c=%0d: got %h expected %h", c, mem_addr, exp_addr);
        end
        exp_id_q.push_back(REQ_PU_LD);
        ret_q.push_back(c + 2);
      end
      if (mem_rd_v) begin
        void'(ret_q.pop_front());
        id = exp_id_q.pop_front();
        checks++;
        if (rd_v !== (2'b01 << id)) begin
          errors++;
          $display("FAIL single_rd_v c=%0d: got %b expected %b", c, rd_v, 2'b01 << id);
        end
      end
      if (c == 3 || c == 6) begin
        checks++;
        if (busy !== (c == 3)) begin
          errors++;
          $display("FAIL single_busy c=%0d: got %b expected %b", c, busy, c == 3);
        end
      end
    end
  endtask

  task automatic test_contention();
    int exp_own [12] = '{-1, 0, 0, -1, 1, 1, -1, 0, 0, -1, 1, 1};
    int beat [2] = '{0, 0};
    int eo, id;
    logic [1:0] exp_rdy;
    logic [7:0] exp_addr;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      req_v     = {beat[1] < 4, beat[0] < 4};
      req_addr  = {8'h40 + 8'(beat[1]), 8'h20 + 8'(beat[0])};
      req_last  = {beat[1] % 2 == 1, beat[0] % 2 == 1};
      mem_ready = 1'b1;
      mem_rd_v  = (ret_q.size() > 0) && (ret_q[0] == c);
      #1;
      eo = (c < 12) ? exp_own[c] : -1;
      exp_rdy = (eo < 0) ? 2'b00 : (2'b01 << eo);
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL contention_grant c=%0d: got %b expected %b", c, req_ready, exp_rdy);
      end
      if (eo >= 0) begin
        exp_addr = (eo == 0) ? 8'h20 + 8'(beat[0]) : 8'h40 + 8'(beat[1]);
        checks++;
        if (mem_addr !== exp_addr) begin
          errors++;
          $display("FAIL contention_addr c=%0d: got %h expected %h", c, mem_addr, exp_addr);
        end
        beat[eo]++;
        exp_id_q.push_back(eo);
        ret_q.push_back(c + 1);
      end
      if (mem_rd_v) begin
        void'(ret_q.pop_front());
        id = exp_id_q.pop_front();
        checks++;
        if (rd_v !== (2'b01 << id)) begin
          errors++;
          $display("FAIL contention_rd_v c=%0d: got %b expected %b", c, rd_v, 2'b01 << id);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL contention_busy_end: got %b expected 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int b0 = 0;
    int id;
    logic acc, stall;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      stall     = (c >= 3 && c <= 5);
      req_v     = {stall, b0 < 4};
      req_addr  = {8'h77, 8'h30 + 8'(b0)};
      req_last  = {1'b1, b0 == 3};
      mem_ready = !stall;
      mem_rd_v  = (ret_q.size() > 0) && (ret_q[0] == c);
      #1;
      acc = (c == 1 || c == 2 || c == 6 || c == 7);
      checks++;
      if ({mem_req, req_ready} !== {acc, 1'b0, acc}) begin
        errors++;
        $display("FAIL backpressure_accept c=%0d: got req=%b rdy=%b expected req=%b rdy=0%b",
                 c, mem_req, req_ready, acc, acc);
      end
      checks++;
      if (mem_addr !== (acc ? 8'h30 + 8'(b0) : 8'h00)) begin
        errors++;
        $display("FAIL backpressure_addr c=%0d: got %h expected %h", c, mem_addr,
                 acc ? 8'h30 + 8'(b0) : 8'h00);
      end
      if (acc) begin
        b0++;
        exp_id_q.push_back(REQ_PU_LD);
        ret_q.push_back(c + 2);
      end
      if (mem_rd_v) begin
        void'(ret_q.pop_front());
        id = exp_id_q.pop_front();
        checks++;
        if (rd_v !== (2'b01 << id)) begin
          errors++;
          $display("FAIL backpressure_rd_v c=%0d: got %b expected %b", c, rd_v, 2'b01 << id);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_busy_end: got %b expected 0", busy);
    end
  endtask

  task automatic test_fifo_full();
    int b0 = 0;
    int id;
    logic acc;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      req_v     = {1'b0, b0 < 6};
      req_addr  = {8'h00, 8'h50 + 8'(b0)};
      req_last  = {1'b0, b0 == 5};
      mem_ready = 1'b1;
      mem_rd_v  = (c == 7) || (c >= 9 && exp_id_q.size() > 0);
      #1;
      acc = (c >= 1 && c <= 4) || c == 8 || c == 10;
      checks++;
      if ({mem_req, req_ready} !== {acc, 1'b0, acc}) begin
        errors++;
        $display("FAIL fifo_full_accept c=%0d: got req=%b rdy=%b expected req=%b rdy=0%b",
                 c, mem_req, req_ready, acc, acc);
      end
      if (acc) begin
        checks++;
        if (mem_addr !== 8'h50 + 8'(b0)) begin
          errors++;
          $display("FAIL fifo_full_addr c=%0d: got %h expected %h", c, mem_addr, 8'h50 + 8'(b0));
        end
        b0++;
        exp_id_q.push_back(REQ_PU_LD);
      end
      if (mem_rd_v) begin
        id = exp_id_q.pop_front();
        checks++;
        if (rd_v !== (2'b01 << id)) begin
          errors++;
          $display("FAIL fifo_full_rd_v c=%0d: got %b expected %b", c, rd_v, 2'b01 << id);
        end
      end
      if (c == 6 || c == 15) begin
        checks++;
        if ({busy, err} !== {c == 6, 1'b0}) begin
          errors++;
          $display("FAIL fifo_full_busy c=%0d: got busy=%b err=%b expected busy=%b err=0",
                   c, busy, err, c == 6);
        end
      end
    end
  endtask

  task automatic test_spurious();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_rd_v = (c == 0);
      req_v    = (c == 2) ? 2'b10 : 2'b00;
      #1;
      checks++;
      if ({rd_v, err} !== {2'b00, c != 0}) begin
        errors++;
        $display("FAIL spurious c=%0d: got rd_v=%b err=%b expected rd_v=00 err=%b", c, rd_v, err, c != 0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL spurious_err_reset: got %b expected 0", err);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_v     = 2'b01;
      req_addr  = {8'h00, 8'h60 + 8'(c == 0 ? 0 : c - 1)};
      req_last  = 2'b00;
      mem_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== ((c == 0) ? 2'b00 : 2'b01)) begin
        errors++;
        $display("FAIL async_pre c=%0d: got %b expected %b", c, req_ready, (c == 0) ? 2'b00 : 2'b01);
      end
    end
    #2;
    reset    = 1'b0;
    mem_rd_v = 1'b1;
    #1;
    checks++;
    if ({mem_req, req_ready, busy, rd_v} !== 6'b0) begin
      errors++;
      $display("FAIL async_assert: got req=%b rdy=%b busy=%b rd_v=%b expected all 0",
               mem_req, req_ready, busy, rd_v);
    end
    @(negedge clk);
    mem_rd_v = 1'b0;
    @(negedge clk);
    reset    = 1'b1;
    req_addr = {8'h00, 8'h62};
    req_last = 2'b01;
    mem_rd_v = 1'b1;
    #1;
    checks++;
    if ({req_ready, rd_v, err} !== 5'b0) begin
      errors++;
      $display("FAIL async_release_idle: got rdy=%b rd_v=%b err=%b expected all 0", req_ready, rd_v, err);
    end
    @(negedge clk);
    mem_rd_v = 1'b0;
    #1;
    checks++;
    if ({err, req_ready, mem_addr} !== {1'b1, 2'b01, 8'h62}) begin
      errors++;
      $display("FAIL async_stale_return: got err=%b rdy=%b addr=%h expected err=1 rdy=01 addr=62",
               err, req_ready, mem_addr);
    end
    @(negedge clk);
    req_v    = 2'b00;
    mem_rd_v = 1'b1;
    #1;
    checks++;
    if (rd_v !== 2'b01) begin
      errors++;
      $display("FAIL async_return_after: got %b expected 01", rd_v);
    end
    @(negedge clk);
    mem_rd_v = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_fifo_full();
    test_spurious();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
